// File: rtl/bram_stream_writer.sv
// Streams handshaken words into a BRAM port at consecutive (wrapping) addresses.
// Optional running checksum of the transfer is enabled with the CHECKSUM_EN macro.
module bram_stream_writer #(
   parameter int unsigned CNT_BIT  = 31,
   parameter int unsigned DWIDTH   = 32,
   parameter int unsigned AWIDTH   = 12,
   parameter int unsigned MEM_SIZE = 4096
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               i_run,
   input  logic [CNT_BIT-1:0] i_num_cnt,
   output logic               o_idle,
   output logic               o_write,
   output logic               o_done,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [DWIDTH-1:0]  s_data,
   output logic [AWIDTH-1:0]  addr_b,
   output logic               ce_b,
   output logic               we_b,
   output logic [DWIDTH-1:0]  d_b
`ifdef CHECKSUM_EN
   ,
   output logic [DWIDTH-1:0]  o_checksum
`endif
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e             state_q, state_d;
   logic [CNT_BIT-1:0] cnt_q, cnt_d;
   logic [CNT_BIT-1:0] num_q, num_d;
   logic [AWIDTH-1:0]  addr_q, addr_d;
   logic [DWIDTH-1:0]  data_q, data_d;
   logic               wr_q, wr_d;
   logic               hs;

   assign hs = s_valid && (state_q == StRun);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      num_d   = num_q;
      addr_d  = addr_q;
      data_d  = data_q;
      wr_d    = 1'b0;
      case (state_q)
         StIdle: begin
            if (i_run) begin
               num_d   = i_num_cnt;
               cnt_d   = '0;
               state_d = (i_num_cnt == '0) ? StDone : StRun;
            end
         end
         StRun: begin
            if (s_valid) begin
               addr_d = cnt_q[AWIDTH-1:0];
               data_d = s_data;
               wr_d   = 1'b1;
               cnt_d  = cnt_q + CNT_BIT'(1);
               if (cnt_q == num_q - CNT_BIT'(1)) begin
                  state_d = StDone;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         num_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         num_q   <= num_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wr_q    <= wr_d;
      end
   end

   assign o_idle  = (state_q == StIdle);
   assign o_write = (state_q == StRun);
   assign o_done  = (state_q == StDone);
   assign s_ready = (state_q == StRun);
   assign addr_b  = addr_q;
   assign d_b     = data_q;
   assign ce_b    = wr_q;
   assign we_b    = wr_q;

`ifdef CHECKSUM_EN
   logic [DWIDTH-1:0] sum_q, sum_d;

   always_comb begin
      sum_d = sum_q;
      if (o_idle && i_run) begin
         sum_d = '0;
      end else if (hs) begin
         sum_d = sum_q + s_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign o_checksum = sum_q;
`endif

   // Addresses beyond the configured depth would land outside the physical BRAM.
   addr_in_range: assert property (@(posedge clk) disable iff (!reset_n)
      ce_b |-> (32'(addr_b) < MEM_SIZE));

endmodule

// File: tb/tb_bram_stream_writer.sv
// Directed bench for bram_stream_writer: scoreboarded write strobes plus a BRAM model.
module tb_bram_stream_writer;

   logic        clk;
   logic        reset_n;
   logic        i_run;
   logic [30:0] i_num_cnt;
   logic        o_idle;
   logic        o_write;
   logic        o_done;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic [11:0] addr_b;
   logic        ce_b;
   logic        we_b;
   logic [31:0] d_b;
`ifdef CHECKSUM_EN
   logic [31:0] o_checksum;
`endif

   bram_stream_writer dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_run     (i_run),
      .i_num_cnt (i_num_cnt),
      .o_idle    (o_idle),
      .o_write   (o_write),
      .o_done    (o_done),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .addr_b    (addr_b),
      .ce_b      (ce_b),
      .we_b      (we_b),
      .d_b       (d_b)
`ifdef CHECKSUM_EN
      ,
      .o_checksum(o_checksum)
`endif
   );

   typedef struct {
      logic [11:0] addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] ram [0:4095];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_strobes = 0;
   int          cyc = 0;
   int          s0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      if (ce_b && we_b) ram[addr_b] <= d_b;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Each strobe must match the oldest pending handshake, exactly one cycle later.
   always @(negedge clk) begin
      if (ce_b !== 1'b0 || we_b !== 1'b0) begin
         if (exp_q.size() == 0) begin
            check("spurious_strobe", {62'd0, ce_b, we_b}, 64'd0);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            n_strobes++;
            check("wr_addr", addr_b, e.addr);
            check("wr_data", d_b, e.data);
            check("wr_we", we_b, 1);
            check("wr_latency", cyc, e.cyc);
         end
      end
   end

   task automatic start(input int n);
      i_run     = 1'b1;
      i_num_cnt = 31'(n);
      @(negedge clk);
      i_run     = 1'b0;
   endtask

   task automatic send(input int idx, input logic [31:0] data);
      wr_t e;
      s_valid = 1'b1;
      s_data  = data;
      check("s_ready", s_ready, 1);
      e.addr = idx[11:0];
      e.data = data;
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic expect_done(input string tag);
      check({tag, "_done"}, o_done, 1);
      check({tag, "_write_in_done"}, o_write, 0);
      @(negedge clk);
      check({tag, "_idle_after"}, o_idle, 1);
      check({tag, "_done_after"}, o_done, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      reset_n   = 1'b1;
      i_run     = 1'b0;
      i_num_cnt = '0;
      s_valid   = 1'b0;
      s_data    = '0;
      #2 reset_n = 1'b0;
      #1;
      check("rst_idle", o_idle, 1);
      check("rst_write", o_write, 0);
      check("rst_done", o_done, 0);
      check("rst_ready", s_ready, 0);
      check("rst_ce", ce_b, 0);
      check("rst_we", we_b, 0);
      check("rst_addr", addr_b, 0);
      check("rst_data", d_b, 0);
`ifdef CHECKSUM_EN
      check("rst_checksum", o_checksum, 0);
`endif
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Eight back-to-back words
      s0 = n_strobes;
      start(8);
      check("t8_write", o_write, 1);
      for (int i = 0; i < 8; i++) send(i, 32'(i));
      expect_done("t8");
      check("t8_strobes", n_strobes - s0, 8);
      for (int i = 0; i < 8; i++) check("t8_ram", ram[i], 32'(i));

      // Four words with s_valid toggling; stray i_run in RUN must be ignored
      s0 = n_strobes;
      start(4);
      for (int i = 0; i < 4; i++) begin
         send(i, 32'(100 + i));
         if (i < 3) begin
            check("t4_done_early", o_done, 0);
            if (i == 1) begin
               i_run     = 1'b1;
               i_num_cnt = 31'd2;
            end
            @(negedge clk);
            i_run = 1'b0;
            check("t4_still_run", o_write, 1);
         end
      end
      expect_done("t4");
      check("t4_strobes", n_strobes - s0, 4);
      check("t4_ram3", ram[3], 32'd103);

      // Zero-length transfer
      s0 = n_strobes;
      start(0);
      check("t0_idle", o_idle, 0);
      expect_done("t0");
      check("t0_strobes", n_strobes - s0, 0);

      // Address wrap past the BRAM depth
      s0 = n_strobes;
      start(4098);
      for (int i = 0; i < 4098; i++) send(i, 32'(i));
      expect_done("twrap");
      check("twrap_strobes", n_strobes - s0, 4098);
      check("twrap_ram0", ram[0], 32'd4096);
      check("twrap_ram1", ram[1], 32'd4097);
      check("twrap_ram2", ram[2], 32'd2);

      // Reset mid-transfer after three of ten words
      s0 = n_strobes;
      start(10);
      for (int i = 0; i < 3; i++) send(i, 32'h0A0 + 32'(i));
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 32'hDEAD;
      reset_n = 1'b0;
      #1;
      check("tabort_idle", o_idle, 1);
      check("tabort_write", o_write, 0);
      check("tabort_ready", s_ready, 0);
      check("tabort_ce", ce_b, 0);
      repeat (2) @(negedge clk);
      s_valid = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
      check("tabort_strobes", n_strobes - s0, 3);
      for (int i = 0; i < 3; i++) check("tabort_ram", ram[i], 32'h0A0 + 32'(i));
      start(2);
      send(0, 32'd55);
      send(1, 32'd66);
      expect_done("trestart");
      check("trestart_ram0", ram[0], 32'd55);
      check("trestart_ram1", ram[1], 32'd66);
      check("trestart_ram2", ram[2], 32'h0A2);

`ifdef CHECKSUM_EN
      start(3);
      send(0, 32'hFFFF_FFFF);
      send(1, 32'd2);
      send(2, 32'd3);
      check("tsum_at_done", o_checksum, 32'd4);
      expect_done("tsum");
      check("tsum_stable", o_checksum, 32'd4);
`endif

      repeat (2) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
